seven_seg_scanner: RTL

Time-multiplexes one of the four 3-digit BCD numbers produced by the number converter onto the board's 4-digit common-anode seven-segment display. The leftmost digit shows the 1-based number index with a decimal point; the right three digits show the number with leading-zero suppression, or `---` for an invalid (0xFFF) slot. The block sits directly downstream of the converter's 48-bit `numbers` bus and drives the display pins.

---
 rtl/seven_seg_scanner_pkg.sv | 55 +++++
 rtl/seven_seg_scanner_decoder.sv | 21 ++
 rtl/seven_seg_scanner.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/seven_seg_scanner_pkg.sv
// Shared display definitions for the seven-segment scanner: segment patterns,
// the invalid-slot marker, anode one-hot codes and the decoder select type.
package seven_seg_scanner_pkg;

  // How the decoder should render the current position.
  typedef enum logic [1:0] {
    SEL_DIGIT = 2'd0,
    SEL_DASH  = 2'd1,
    SEL_BLANK = 2'd2
  } seg_sel_e;

  // Segment patterns, active-low, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // A BCD slot of all ones means the converter had no valid number.
  localparam logic [11:0] INVALID_NUM = 12'hFFF;

  // Anode enables, active-low; position 0 is the rightmost digit.
  localparam logic [3:0] AN_POS0 = 4'b1110;
  localparam logic [3:0] AN_POS1 = 4'b1101;
  localparam logic [3:0] AN_POS2 = 4'b1011;
  localparam logic [3:0] AN_POS3 = 4'b0111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  // Pattern for a BCD digit; non-decimal codes render blank.
  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seven_seg_scanner_decoder.sv
// Combinational seven-segment decoder: a BCD digit or a forced dash/blank
// becomes an active-low segment pattern.
module seg7_decoder
  import seven_seg_scanner_pkg::*;
(
  input  logic [3:0] digit_i,
  input  seg_sel_e   sel_i,
  output logic [6:0] seg_o
);

  // Select between the digit pattern and the fixed dash/blank patterns.
  always_comb begin
    seg_o = SEG_BLANK;
    case (sel_i)
      SEL_DIGIT: seg_o = seg_digit(digit_i);
      SEL_DASH:  seg_o = SEG_DASH;
      default:   seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Four-digit common-anode display scanner. The leftmost digit shows the
// 1-based page index (with decimal point, optionally blinking); the right
// three digits show the selected BCD number with leading-zero suppression,
// or dashes for an invalid slot. Content is snapshotted once per frame.
module seven_seg_scanner
  import seven_seg_scanner_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [47:0] numbers,
  input  logic [1:0]  page,
  input  logic        blink_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int TW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [1:0]    pos_q, pos_d;
  logic [11:0]   snap_num_q, snap_num_d;
  logic [1:0]    snap_page_q, snap_page_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          blink_phase_q, blink_phase_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          tick;
  logic          frame_end;
  logic [11:0]   page_num;
  logic [3:0]    hund, tens, ones;
  logic          invalid;
  logic          idx_hidden;
  logic [3:0]    dig_val;
  seg_sel_e      dig_sel;

  assign tick      = (tick_cnt_q == TW'(REFRESH_DIV - 1));
  assign frame_end = tick && (pos_q == 2'd3);

  assign hund       = snap_num_q[11:8];
  assign tens       = snap_num_q[7:4];
  assign ones       = snap_num_q[3:0];
  assign invalid    = (snap_num_q == INVALID_NUM);
  assign idx_hidden = blink_en && !blink_phase_q;

  // Pick the number slot addressed by page; number 0 lives in the top bits.
  always_comb begin
    page_num = numbers[47:36];
    case (page)
      2'd0: page_num = numbers[47:36];
      2'd1: page_num = numbers[35:24];
      2'd2: page_num = numbers[23:12];
      2'd3: page_num = numbers[11:0];
      default: page_num = numbers[47:36];
    endcase
  end

  // Refresh timing, scan position, per-frame snapshot and blink phase.
  always_comb begin
    tick_cnt_d    = tick ? '0 : tick_cnt_q + TW'(1);
    pos_d         = tick ? pos_q + 2'd1 : pos_q;
    snap_num_d    = snap_num_q;
    snap_page_d   = snap_page_q;
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;

    // The snapshot only moves at a frame boundary so a frame never tears.
    if (frame_end) begin
      snap_num_d  = page_num;
      snap_page_d = page;
    end

    // Blink disabled parks the phase visible so re-enabling starts visible.
    if (!blink_en) begin
      frame_cnt_d   = '0;
      blink_phase_d = 1'b1;
    end else if (frame_end) begin
      if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
        frame_cnt_d   = '0;
        blink_phase_d = !blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FW'(1);
      end
    end
  end

  // Digit content for the current scan position, taken from the snapshot.
  always_comb begin
    an_d    = AN_POS0;
    dig_val = ones;
    dig_sel = SEL_BLANK;
    dp_d    = 1'b1;
    case (pos_q)
      2'd0: begin
        an_d    = AN_POS0;
        dig_val = ones;
        if (invalid)           dig_sel = SEL_DASH;
        else if (ones > 4'd9)  dig_sel = SEL_BLANK;
        else                   dig_sel = SEL_DIGIT;
      end
      2'd1: begin
        an_d    = AN_POS1;
        dig_val = tens;
        if (invalid)                                      dig_sel = SEL_DASH;
        else if ((hund == 4'd0 && tens == 4'd0) || tens > 4'd9) dig_sel = SEL_BLANK;
        else                                              dig_sel = SEL_DIGIT;
      end
      2'd2: begin
        an_d    = AN_POS2;
        dig_val = hund;
        if (invalid)                          dig_sel = SEL_DASH;
        else if (hund == 4'd0 || hund > 4'd9) dig_sel = SEL_BLANK;
        else                                  dig_sel = SEL_DIGIT;
      end
      default: begin
        an_d    = AN_POS3;
        dig_val = {2'b00, snap_page_q} + 4'd1;
        dig_sel = idx_hidden ? SEL_BLANK : SEL_DIGIT;
        dp_d    = idx_hidden;
      end
    endcase
  end

  seg7_decoder u_dec (
    .digit_i (dig_val),
    .sel_i   (dig_sel),
    .seg_o   (seg_d)
  );

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tick_cnt_q    <= '0;
      pos_q         <= 2'd0;
      snap_num_q    <= INVALID_NUM;
      snap_page_q   <= 2'd0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      an_q          <= AN_OFF;
      seg_q         <= SEG_BLANK;
      dp_q          <= 1'b1;
    end else begin
      tick_cnt_q    <= tick_cnt_d;
      pos_q         <= pos_d;
      snap_num_q    <= snap_num_d;
      snap_page_q   <= snap_page_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule
